pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
Parameterised pulse-width modulator that produces a single-bit PWM waveform from a programmable period and duty value.
- An optional clock prescaler stretches each PWM count step over CLK_DIV clock cycles.
- Duty and period are double-buffered and only take effect at a PWM cycle boundary, so the output never glitches.
- Used as a general-purpose timer/actuator driver (LED dimming, motor drive) attached to a control register block.

Parameters:
WIDTH, 8, bit width of duty, period and the internal cycle counter.
CLK_DIV, 1, prescaler ratio: clock cycles per counter step; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = PWM running; 0 = output forced low, counters cleared.
duty  input  WIDTH  high time in counter steps; 0 = always low; duty > period = always high.
period  input  WIDTH  cycle length minus one, in counter steps; cycle = period+1 steps.
pwm_out  output  1  registered PWM output.

Behaviour:
- Reset (rst=1, asynchronous):
  - prescaler = 0, cnt = 0, pwm_out = 0.
  - duty_act = 0, period_act = all-ones.
- Prescaler:
  - presc counts 0..CLK_DIV-1 while enable=1.
  - tick = (presc == CLK_DIV-1); presc wraps to 0 on tick.
  - CLK_DIV=1 gives tick on every clock.
- Cycle counter (WIDTH bits), advances only on tick:
  - If cnt >= period_act: cnt <= 0, and duty_act <= duty, period_act <= period (shadow load).
  - Otherwise cnt <= cnt + 1.
  - The >= comparison guarantees recovery if period_act shrinks below cnt.
- Output: pwm_out <= enable & (cnt < duty_act), registered, giving one clock of latency from cnt to pin.
  - duty_act = 0: output constantly low.
  - duty_act > period_act: output constantly high, for example duty=255 with period=254.
  - duty_act = period_act + 1 = 2^WIDTH is not representable, so 100% requires period < 2^WIDTH-1.
  - With period=255 and duty=255, high time is 255 of 256 steps.
- Period = 0: each cycle is 1 step; output high iff duty_act >= 1.
- Enable deasserted:
  - Synchronously on the next clock: presc = 0, cnt = 0, pwm_out = 0.
  - duty_act/period_act load the live inputs every clock while disabled.
  - On re-enable, the first cycle starts at cnt = 0 with the current duty/period. The first high output appears one clock after enable rises (when duty > 0).
- Duty/period changes while enabled:
  - Ignored until the current cycle ends (cnt reaches period_act on a tick).
  - Never truncate or extend a cycle in progress.
- Steady-state waveform per cycle: min(duty_act, period_act+1) steps high, then the remainder low, repeating exactly every (period_act+1)*CLK_DIV clocks.
- Arithmetic: all comparisons unsigned, WIDTH bits; no overflow, since cnt never exceeds period_act.
- Reset mid-cycle: immediate low output and full state clear regardless of enable.

Test Plan:
- Reset: hold rst=1 for 2 clocks, release with enable=0 -> pwm_out=0 and remains 0.
- 50% duty: CLK_DIV=1, period=99, duty=50, enable=1, settle 300 clocks -> every 100-clock window has exactly 50 high and 50 low; rising edges 100 clocks apart.
- Duty sweep with period=99:
  - duty=0 -> 0 high over 100 clocks.
  - duty=25/50/75 -> exactly 25/50/75 high clocks per cycle.
  - duty=100 -> pwm_out high for all 100 clocks.
- Disable: running at duty=50, drop enable -> pwm_out=0 within 1 clock and stays low for 50 clocks. Re-enable -> first high one clock later; first cycle is a full 50 high / 50 low.
- Glitch-free update: period=255, change duty 51->204 mid-cycle -> current cycle keeps 51 high steps; the next cycle has 204 high. Ramp 0,51,...,255 then back down, 512 clocks each -> no runt pulses and period stays 256.
- Prescaler: CLK_DIV=4, period=9, duty=3 -> 12 clocks high, 28 low, period 40 clocks.

Source files
------------

// File: rtl/pwm_generator.sv
// PWM generator: optional prescaler, cycle counter, and duty/period shadow registers.
// Shadow registers load only at cycle boundaries. Output is registered, with one clock from cnt to pin.
module pwm_generator #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] period,
  output logic             pwm_out
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_act;
  logic [WIDTH-1:0] period_act;
  logic             tick;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      cnt        <= '0;
      pwm_out    <= 1'b0;
      duty_act   <= '0;
      period_act <= '1;
    end else if (!enable) begin
      // Track live inputs so the first cycle after enable uses current settings
      presc      <= '0;
      cnt        <= '0;
      pwm_out    <= 1'b0;
      duty_act   <= duty;
      period_act <= period;
    end else begin
      pwm_out <= (cnt < duty_act);
      if (tick) begin
        presc <= '0;
        // >= rather than == so a shrunken period can never strand cnt above it
        if (cnt >= period_act) begin
          cnt        <= '0;
          duty_act   <= duty;
          period_act <= period;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed waveform checks plus random stimulus against a cycle-position model,
// with instances at CLK_DIV=1 and CLK_DIV=4.
module tb_pwm_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] duty;
  logic [7:0] period;
  logic       pwm1;
  logic       pwm4;

  int n_cmp = 0;
  int n_err = 0;

  pwm_generator #(.WIDTH(8), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty), .period(period), .pwm_out(pwm1)
  );
  pwm_generator #(.WIDTH(8), .CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .enable(enable), .duty(duty), .period(period), .pwm_out(pwm4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position within the current cycle in clocks; a cycle spans (period+1)*div clocks
  // and the output is high while the elapsed step count (pos/div) is below the latched duty.
  localparam int DIV [2] = '{1, 4};
  int m_pos [2];
  int m_duty [2];
  int m_per [2];
  bit m_exp [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pos[i] = 0; m_duty[i] = 0; m_per[i] = 255; m_exp[i] = 1'b0;
      end else if (!enable) begin
        m_pos[i] = 0; m_duty[i] = duty; m_per[i] = period; m_exp[i] = 1'b0;
      end else begin
        m_exp[i] = (m_pos[i] / DIV[i]) < m_duty[i];
        m_pos[i]++;
        if (m_pos[i] == (m_per[i] + 1) * DIV[i]) begin
          m_pos[i] = 0; m_duty[i] = duty; m_per[i] = period;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_d1", pwm1, m_exp[0]);
    chk("model_d4", pwm4, m_exp[1]);
  end

  function automatic logic pick(input int which);
    return (which == 0) ? pwm1 : pwm4;
  endfunction

  task automatic count_high(input int which, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pick(which)) hi++;
    end
  endtask

  // Clocks between two consecutive rising edges; -1 if fewer than two edges occur within budget
  task automatic rise_gap(input int which, input int budget, output int gap);
    int  t0;
    int  found;
    logic prev;
    gap = -1; found = 0; t0 = 0;
    @(negedge clk);
    prev = pick(which);
    for (int c = 1; c <= budget && found < 2; c++) begin
      @(negedge clk);
      if (!prev && pick(which)) begin
        if (found == 0) t0 = c; else gap = c - t0;
        found++;
      end
      prev = pick(which);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hi;
  int gap;
  int dl [5] = '{0, 25, 50, 75, 100};

  initial begin
    rst = 1'b1; enable = 1'b0; duty = '0; period = '0;
    clocks(2);
    rst = 1'b0;
    chk("reset_out", pwm1, 0);
    count_high(0, 10, hi);
    chk("reset_hold", hi, 0);

    // 50% duty at period 99
    period = 8'd99; duty = 8'd50;
    clocks(1);
    enable = 1'b1;
    clocks(300);
    count_high(0, 100, hi);
    chk("half_high", hi, 50);
    rise_gap(0, 300, gap);
    chk("half_gap", gap, 100);

    foreach (dl[k]) begin
      duty = 8'(dl[k]);
      clocks(200);
      count_high(0, 100, hi);
      chk($sformatf("sweep_%0d", dl[k]), hi, dl[k]);
    end

    // Disable / re-enable
    duty = 8'd50;
    clocks(200);
    enable = 1'b0;
    count_high(0, 50, hi);
    chk("dis_low", hi, 0);
    enable = 1'b1;
    count_high(0, 50, hi);
    chk("reen_first_high", hi, 50);
    count_high(0, 50, hi);
    chk("reen_first_low", hi, 0);

    // Mid-cycle duty change must not disturb the running cycle
    enable = 1'b0; period = 8'd255; duty = 8'd51;
    clocks(1);
    enable = 1'b1;
    count_high(0, 20, hi);
    duty = 8'd204;
    begin
      int h2;
      count_high(0, 236, h2);
      chk("glitch_cur", hi + h2, 51);
    end
    count_high(0, 256, hi);
    chk("glitch_next", hi, 204);

    for (int d = 0; d <= 255; d += 51) begin
      duty = 8'(d);
      clocks(256);
      count_high(0, 256, hi);
      chk($sformatf("ramp_up_%0d", d), hi, d);
    end
    for (int d = 204; d >= 0; d -= 51) begin
      duty = 8'(d);
      clocks(256);
      count_high(0, 256, hi);
      chk($sformatf("ramp_dn_%0d", d), hi, d);
    end

    // duty > period keeps the output permanently high
    duty = 8'd255; period = 8'd254;
    clocks(300);
    count_high(0, 255, hi);
    chk("full_on", hi, 255);

    // Single-step cycles
    period = 8'd0; duty = 8'd1;
    clocks(300);
    count_high(0, 10, hi);
    chk("p0_d1", hi, 10);
    duty = 8'd0;
    clocks(3);
    count_high(0, 10, hi);
    chk("p0_d0", hi, 0);

    // Prescaler
    enable = 1'b0; period = 8'd9; duty = 8'd3;
    clocks(1);
    enable = 1'b1;
    clocks(80);
    count_high(1, 40, hi);
    chk("presc_high", hi, 12);
    rise_gap(1, 120, gap);
    chk("presc_gap", gap, 40);

    // Random traffic, including async reset pulses between edges
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 199);
      if (r < 4) enable = ~enable;
      else if (r < 14) duty = 8'($urandom_range(0, 30));
      else if (r < 24) period = 8'($urandom_range(0, 25));
      else if (r == 24) duty = 8'($urandom);
      else if (r == 25) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
